sram_read_arbiter: RTL

SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

---
 rtl/sram_read_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_read_arbiter.sv
// Two-client round-robin arbiter sharing one read port of a 256x32 SDP block SRAM.
// Optional burst regrant of the last owner is compiled in when SRAM_ARB_BURST_EN is defined.
module sram_read_arbiter #(
    parameter int DELAY     = 3,
    parameter int BURST_LEN = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic [7:0]  addr0_i,
    output logic        ack0_o,
    output logic [31:0] dat0_o,
    input  logic        req1_i,
    input  logic [7:0]  addr1_i,
    output logic        ack1_o,
    output logic [31:0] dat1_o,
    output logic        sram_ce_o,
    output logic [7:0]  sram_raddr_o,
    input  logic [31:0] sram_do_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   grant_valid;
    logic   grant_sel;
    logic   rr_sel;
    logic   pick;

    // DELAY only shapes simulation models of register timing; out-of-range values leave a marker here.
    if (DELAY < 0 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_params
    end

    // A tie goes to the client not granted last; a lone requester simply wins.
    assign rr_sel = (req0_i && req1_i) ? ~last_grant : req1_i;

`ifdef SRAM_ARB_BURST_EN
    logic [3:0] burst_cnt;
    logic       owner_req;
    logic       burst_hold;

    assign owner_req  = last_grant ? req1_i : req0_i;
    // A zero count means the owner has lost its burst claim.
    assign burst_hold = owner_req && (burst_cnt != 4'd0) && (burst_cnt < 4'(BURST_LEN));
    assign pick       = burst_hold ? last_grant : rr_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            burst_cnt <= 4'd0;
        end else if (grant_valid) begin
            if (grant_sel != last_grant) begin
                burst_cnt <= 4'd1;
            end else if (burst_cnt < 4'(BURST_LEN)) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end else if (state == IDLE && !owner_req) begin
            burst_cnt <= 4'd0;
        end
    end
`else
    assign pick = rr_sel;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = last_grant;
        case (state)
            IDLE: begin
                if (req0_i || req1_i) begin
                    grant_valid = 1'b1;
                    grant_sel   = pick;
                    state_next  = READ;
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the read in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sram_ce_o    <= 1'b0;
            sram_raddr_o <= 8'h00;
            ack0_o       <= 1'b0;
            ack1_o       <= 1'b0;
            dat0_o       <= 32'h0;
            dat1_o       <= 32'h0;
            last_grant   <= 1'b1;
        end else begin
            sram_ce_o <= grant_valid;
            ack0_o    <= 1'b0;
            ack1_o    <= 1'b0;
            if (grant_valid) begin
                sram_raddr_o <= grant_sel ? addr1_i : addr0_i;
                last_grant   <= grant_sel;
            end
            if (state == WAIT) begin
                if (last_grant) begin
                    dat1_o <= sram_do_i;
                    ack1_o <= 1'b1;
                end else begin
                    dat0_o <= sram_do_i;
                    ack0_o <= 1'b1;
                end
            end
        end
    end

endmodule
